riscv_vec_dmem_arbiter: RTL and testbench
=========================================

Name: riscv_vec_dmem_arbiter

Overview:
Shares one data-memory request/response port pair among the four vector-lane memory ports (lanes 0-3) of the 7-stage RISCV core. The block sits between the core's v_dmemreq/v_dmemresp lane ports and a single memory port.
- Requests are granted round-robin.
- An in-order tag queue records the lane of each outstanding request, and each response is routed back to that lane.
- Memory responses are assumed in request order; there is no response ready signal.

Parameters:
REQ_W, 67, request message width, equal to VC_MEM_REQ_MSG_SZ(32,32)
RESP_W, 35, response message width, equal to VC_MEM_RESP_MSG_SZ(32)
ORDQ_DEPTH, 4, maximum outstanding requests; power of two, at least 2

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
v_dmemreq_msg_0..3  in  REQ_W each  lane request messages
v_dmemreq_val_0..3  in  1 each  lane request valid
v_dmemreq_rdy_0..3  out  1 each  lane request ready
v_dmemresp_msg_0..3  out  RESP_W each  lane response messages
v_dmemresp_val_0..3  out  1 each  lane response valid
memreq_msg  out  REQ_W  shared memory request
memreq_val  out  1  shared memory request valid
memreq_rdy  in  1  shared memory request ready
memresp_msg  in  RESP_W  shared memory response
memresp_val  in  1  shared memory response valid
outstanding  out  3  count of in-flight requests (0..ORDQ_DEPTH)
err_orphan_resp  out  1  sticky: a response arrived while the queue was empty

Behaviour:
- Reset (reset=0, asynchronous):
  - rr_ptr=0; queue head, tail and count = 0; err_orphan_resp=0.
  - All val/rdy outputs are 0 while in reset, because count=0 and the outputs are gated.
- Arbitration (combinational each cycle):
  - The winner is the first valid lane at or after rr_ptr, scanning modulo 4.
  - can_issue = any lane valid AND count<ORDQ_DEPTH.
  - memreq_val = can_issue.
  - memreq_msg = winner's message; 0 when not can_issue.
  - v_dmemreq_rdy_i = can_issue AND (winner==i) AND memreq_rdy. Losing lanes see rdy=0.
  - memreq_val must not depend on memreq_rdy.
- Issue fire: memreq_val & memreq_rdy.
  - The winner id is pushed at the queue tail.
  - rr_ptr <= winner+1 (mod 4).
  - With no fire, rr_ptr holds.
- Full queue:
  - When count==ORDQ_DEPTH, memreq_val=0 even if a response pops in the same cycle.
  - Fullness is evaluated on registered count; a push is never combinationally enabled by a same-cycle pop.
- Response path:
  - When memresp_val=1 and count>0: v_dmemresp_val_i = (head_id==i), and v_dmemresp_msg_i = memresp_msg for all i (only the valid lane matters). The head is popped that cycle.
  - Lanes must accept the response in that cycle; there is no backpressure.
- Orphan response: memresp_val=1 with count==0 sets err_orphan_resp. It is sticky until reset, produces no lane valid, and does not change pointers.
- Simultaneous push and pop: count unchanged; head and tail both advance.
- Latency:
  - Request pass-through: 0 cycles (combinational).
  - Response routing: 0 cycles from memresp_val.
  - Minimum round trip is set by memory.
- Counters: pointers wrap modulo ORDQ_DEPTH. outstanding = count.
- Lane message stability: a lane must hold msg/val until its rdy. A lane dropping val before grant simply loses arbitration that cycle; no state changes.

Optional Feature:
Macro RISCV_VMEMARB_SCALAR_PORT_EN.
- Defined:
  - Adds ports dmemreq_msg (in, REQ_W), dmemreq_val (in), dmemreq_rdy (out), dmemresp_msg (out, RESP_W) and dmemresp_val (out).
  - The scalar port is requester id 4 with strict priority over all lanes.
  - When the scalar port is granted, rr_ptr does not advance.
  - Queue ids widen to 3 bits.
  - Responses with head_id==4 go to dmemresp.
- Undefined: lanes only; queue ids are 2 bits; no scalar ports.

Test Plan:
- All four lanes valid continuously, memreq_rdy=1, memory responds 2 cycles later → grant order 0,1,2,3,0,1; each lane receives its own response tag; outstanding peaks at 2.
- Lane 2 alone valid with memreq_rdy=0 for 3 cycles, then 1 → memreq_val=1 throughout; v_dmemreq_rdy_2=1 only on cycle 4; one push.
- Issue 4 requests with no response → outstanding=4; memreq_val=0 despite valid lanes. Then one response plus a lane request in the same cycle → no grant that cycle; grant the next cycle.
- memresp_val pulse at count=0 → err_orphan_resp=1, no lane valid; remains 1 until reset=0.
- With 3 outstanding, assert reset=0 mid-stream → outputs drop asynchronously; after release outstanding=0, rr_ptr=0, and the first grant goes to the lowest valid lane.
- With RISCV_VMEMARB_SCALAR_PORT_EN, scalar and lanes 1 and 3 all valid → scalar is granted first, then lanes 1 and 3; the scalar response returns on dmemresp_val.

Source files
------------

// File: rtl/riscv_vec_dmem_arbiter.sv
// riscv_vec_dmem_arbiter: round-robin share of one data-memory port among four vector lanes, with in-order response routing.
// Optional scalar requester (id 4, strict priority) enabled by RISCV_VMEMARB_SCALAR_PORT_EN.
module riscv_vec_dmem_arbiter #(
    parameter int REQ_W      = 67,
    parameter int RESP_W     = 35,
    parameter int ORDQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REQ_W-1:0]  v_dmemreq_msg_0,
    input  logic [REQ_W-1:0]  v_dmemreq_msg_1,
    input  logic [REQ_W-1:0]  v_dmemreq_msg_2,
    input  logic [REQ_W-1:0]  v_dmemreq_msg_3,
    input  logic              v_dmemreq_val_0,
    input  logic              v_dmemreq_val_1,
    input  logic              v_dmemreq_val_2,
    input  logic              v_dmemreq_val_3,
    output logic              v_dmemreq_rdy_0,
    output logic              v_dmemreq_rdy_1,
    output logic              v_dmemreq_rdy_2,
    output logic              v_dmemreq_rdy_3,
    output logic [RESP_W-1:0] v_dmemresp_msg_0,
    output logic [RESP_W-1:0] v_dmemresp_msg_1,
    output logic [RESP_W-1:0] v_dmemresp_msg_2,
    output logic [RESP_W-1:0] v_dmemresp_msg_3,
    output logic              v_dmemresp_val_0,
    output logic              v_dmemresp_val_1,
    output logic              v_dmemresp_val_2,
    output logic              v_dmemresp_val_3,
`ifdef RISCV_VMEMARB_SCALAR_PORT_EN
    input  logic [REQ_W-1:0]  dmemreq_msg,
    input  logic              dmemreq_val,
    output logic              dmemreq_rdy,
    output logic [RESP_W-1:0] dmemresp_msg,
    output logic              dmemresp_val,
`endif
    output logic [REQ_W-1:0]  memreq_msg,
    output logic              memreq_val,
    input  logic              memreq_rdy,
    input  logic [RESP_W-1:0] memresp_msg,
    input  logic              memresp_val,
    output logic [2:0]        outstanding,
    output logic              err_orphan_resp
);
    localparam int PTR_W = $clog2(ORDQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef RISCV_VMEMARB_SCALAR_PORT_EN
    localparam int ID_W = 3;
`else
    localparam int ID_W = 2;
`endif

    logic [3:0]       lane_val;
    logic [REQ_W-1:0] lane_msg [4];
    logic [1:0]       rr_ptr, rr_win;
    logic [ID_W-1:0]  win_id, head_id;
    logic [REQ_W-1:0] win_msg;
    logic             any_val, scalar_win, can_issue, fire, pop;
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    logic [ID_W-1:0]  ordq [ORDQ_DEPTH];

    assign lane_val    = {v_dmemreq_val_3, v_dmemreq_val_2, v_dmemreq_val_1, v_dmemreq_val_0};
    assign lane_msg[0] = v_dmemreq_msg_0;
    assign lane_msg[1] = v_dmemreq_msg_1;
    assign lane_msg[2] = v_dmemreq_msg_2;
    assign lane_msg[3] = v_dmemreq_msg_3;

    // Scan downward so the nearest valid lane at or after rr_ptr wins last.
    always_comb begin
        rr_win = rr_ptr;
        for (int k = 3; k >= 0; k--)
            if (lane_val[rr_ptr + 2'(k)]) rr_win = rr_ptr + 2'(k);
    end

`ifdef RISCV_VMEMARB_SCALAR_PORT_EN
    assign scalar_win   = dmemreq_val;
    assign any_val      = |lane_val | dmemreq_val;
    assign win_id       = scalar_win ? ID_W'(4) : ID_W'(rr_win);
    assign win_msg      = scalar_win ? dmemreq_msg : lane_msg[rr_win];
    assign dmemreq_rdy  = fire & scalar_win;
    assign dmemresp_msg = memresp_msg;
    assign dmemresp_val = pop & (head_id == ID_W'(4));
`else
    assign scalar_win = 1'b0;
    assign any_val    = |lane_val;
    assign win_id     = rr_win;
    assign win_msg    = lane_msg[rr_win];
`endif

    // Outputs are gated by reset so nothing is offered while the block is held.
    assign can_issue  = reset & any_val & (count < CNT_W'(ORDQ_DEPTH));
    assign fire       = can_issue & memreq_rdy;
    assign pop        = memresp_val & (count != '0);
    assign head_id    = ordq[head];
    assign memreq_val = can_issue;
    assign memreq_msg = can_issue ? win_msg : '0;

    assign v_dmemreq_rdy_0 = fire & ~scalar_win & (rr_win == 2'd0);
    assign v_dmemreq_rdy_1 = fire & ~scalar_win & (rr_win == 2'd1);
    assign v_dmemreq_rdy_2 = fire & ~scalar_win & (rr_win == 2'd2);
    assign v_dmemreq_rdy_3 = fire & ~scalar_win & (rr_win == 2'd3);

    assign v_dmemresp_msg_0 = memresp_msg;
    assign v_dmemresp_msg_1 = memresp_msg;
    assign v_dmemresp_msg_2 = memresp_msg;
    assign v_dmemresp_msg_3 = memresp_msg;
    assign v_dmemresp_val_0 = pop & (head_id == ID_W'(0));
    assign v_dmemresp_val_1 = pop & (head_id == ID_W'(1));
    assign v_dmemresp_val_2 = pop & (head_id == ID_W'(2));
    assign v_dmemresp_val_3 = pop & (head_id == ID_W'(3));

    assign outstanding = 3'(count);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr          <= '0;
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            err_orphan_resp <= 1'b0;
        end else begin
            if (fire) tail <= tail + PTR_W'(1);
            if (fire && !scalar_win) rr_ptr <= rr_win + 2'd1;
            if (pop) head <= head + PTR_W'(1);
            count <= count + CNT_W'(fire) - CNT_W'(pop);
            if (memresp_val && count == '0) err_orphan_resp <= 1'b1;
        end
    end

    // Tag storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (fire) ordq[tail] <= win_id;
    end
endmodule

// File: tb/tb_riscv_vec_dmem_arbiter.sv
// tb_riscv_vec_dmem_arbiter: directed vector table, reset corner sequence and randomized run against a queue-based reference model.
module tb_riscv_vec_dmem_arbiter;
    localparam int REQ_W  = 67;
    localparam int RESP_W = 35;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [REQ_W-1:0]  lmsg [4];
    logic [3:0]        lval;
    logic              mrdy, rv;
    logic [RESP_W-1:0] rmsg;
    logic [3:0]        lrdy, rval;
    logic [RESP_W-1:0] rmsg_o [4];
    logic [REQ_W-1:0]  mmsg;
    logic              mval, err;
    logic [2:0]        outst;

    int checks = 0;
    int errors = 0;
    int rr_m;
    int q_m[$];
    bit err_m;

    always #5 clk = ~clk;

    riscv_vec_dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .v_dmemreq_msg_0(lmsg[0]), .v_dmemreq_msg_1(lmsg[1]),
        .v_dmemreq_msg_2(lmsg[2]), .v_dmemreq_msg_3(lmsg[3]),
        .v_dmemreq_val_0(lval[0]), .v_dmemreq_val_1(lval[1]),
        .v_dmemreq_val_2(lval[2]), .v_dmemreq_val_3(lval[3]),
        .v_dmemreq_rdy_0(lrdy[0]), .v_dmemreq_rdy_1(lrdy[1]),
        .v_dmemreq_rdy_2(lrdy[2]), .v_dmemreq_rdy_3(lrdy[3]),
        .v_dmemresp_msg_0(rmsg_o[0]), .v_dmemresp_msg_1(rmsg_o[1]),
        .v_dmemresp_msg_2(rmsg_o[2]), .v_dmemresp_msg_3(rmsg_o[3]),
        .v_dmemresp_val_0(rval[0]), .v_dmemresp_val_1(rval[1]),
        .v_dmemresp_val_2(rval[2]), .v_dmemresp_val_3(rval[3]),
        .memreq_msg(mmsg), .memreq_val(mval), .memreq_rdy(mrdy),
        .memresp_msg(rmsg), .memresp_val(rv),
        .outstanding(outst), .err_orphan_resp(err)
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: first valid lane at or after rr, a FIFO of lane ids, sticky orphan flag.
    task automatic model_step();
        int  w;
        bit  ev, found;
        logic [3:0] erdy, erval;
        ev = (lval != 4'b0) && (q_m.size() < 4);
        w = 0;
        found = 0;
        for (int k = 0; k < 4; k++)
            if (!found && lval[(rr_m + k) % 4]) begin
                w = (rr_m + k) % 4;
                found = 1;
            end
        erdy  = (ev && mrdy) ? 4'(1 << w) : 4'b0;
        erval = (rv && q_m.size() > 0) ? 4'(1 << q_m[0]) : 4'b0;
        check("memreq_val", 128'(mval), 128'(ev));
        check("memreq_msg", 128'(mmsg), ev ? 128'(lmsg[w]) : 128'(0));
        check("lane_rdy", 128'(lrdy), 128'(erdy));
        check("resp_val", 128'(rval), 128'(erval));
        if (erval != 4'b0) check("resp_msg", 128'(rmsg_o[q_m[0]]), 128'(rmsg));
        check("outstanding", 128'(outst), 128'(q_m.size()));
        check("err_orphan", 128'(err), 128'(err_m));
        if (rv) begin
            if (q_m.size() > 0) void'(q_m.pop_front());
            else err_m = 1;
        end
        if (ev && mrdy) begin
            q_m.push_back(w);
            rr_m = (w + 1) % 4;
        end
    endtask

    typedef struct {
        logic [3:0] lv;
        logic       mr, rsp, ev;
        logic [3:0] erdy, erval;
        logic [2:0] eout;
        logic       eerr;
    } vec_t;

    vec_t tv [18];

    initial begin
        tv[0]  = '{4'b0100, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 3'd0, 1'b0};
        tv[1]  = '{4'b0100, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 3'd0, 1'b0};
        tv[2]  = '{4'b0100, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 3'd0, 1'b0};
        tv[3]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 4'b0000, 3'd0, 1'b0};
        tv[4]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0100, 3'd1, 1'b0};
        tv[5]  = '{4'b1111, 1'b1, 1'b0, 1'b1, 4'b1000, 4'b0000, 3'd0, 1'b0};
        tv[6]  = '{4'b1111, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000, 3'd1, 1'b0};
        tv[7]  = '{4'b1111, 1'b1, 1'b0, 1'b1, 4'b0010, 4'b0000, 3'd2, 1'b0};
        tv[8]  = '{4'b1111, 1'b1, 1'b0, 1'b1, 4'b0100, 4'b0000, 3'd3, 1'b0};
        tv[9]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1000, 3'd4, 1'b0};
        tv[10] = '{4'b1111, 1'b1, 1'b0, 1'b1, 4'b1000, 4'b0000, 3'd3, 1'b0};
        tv[11] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001, 3'd4, 1'b0};
        tv[12] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0010, 3'd3, 1'b0};
        tv[13] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0100, 3'd2, 1'b0};
        tv[14] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1000, 3'd1, 1'b0};
        tv[15] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0};
        tv[16] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0};
        tv[17] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b1};

        for (int i = 0; i < 4; i++) lmsg[i] = REQ_W'(32'h1000 + i);
        lval = 4'b1111;
        mrdy = 1'b1;
        rv   = 1'b0;
        rmsg = RESP_W'(35'h5_1234_5678);
        #12;
        check("rst_memreq_val", 128'(mval), 128'(0));
        check("rst_lane_rdy", 128'(lrdy), 128'(0));
        check("rst_outstanding", 128'(outst), 128'(0));
        check("rst_err", 128'(err), 128'(0));

        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 18; i++) begin
            lval = tv[i].lv;
            mrdy = tv[i].mr;
            rv   = tv[i].rsp;
            #1;
            check($sformatf("tv%0d_memreq_val", i), 128'(mval), 128'(tv[i].ev));
            check($sformatf("tv%0d_lane_rdy", i), 128'(lrdy), 128'(tv[i].erdy));
            check($sformatf("tv%0d_resp_val", i), 128'(rval), 128'(tv[i].erval));
            check($sformatf("tv%0d_outstanding", i), 128'(outst), 128'(tv[i].eout));
            check($sformatf("tv%0d_err", i), 128'(err), 128'(tv[i].eerr));
            @(negedge clk);
        end

        // Three grants (lanes 0,1,2), then an asynchronous reset mid-cycle.
        lval = 4'b1111;
        mrdy = 1'b1;
        rv   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("pre_reset_outstanding", 128'(outst), 128'(3));
        check("pre_reset_memreq_msg", 128'(mmsg), 128'(lmsg[3]));
        #2;
        reset = 1'b0;
        #1;
        check("async_memreq_val", 128'(mval), 128'(0));
        check("async_lane_rdy", 128'(lrdy), 128'(0));
        check("async_outstanding", 128'(outst), 128'(0));
        check("async_err_clear", 128'(err), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        lval  = 4'b1010;
        #1;
        check("post_reset_first_grant", 128'(lrdy), 128'(4'b0010));
        check("post_reset_memreq_val", 128'(mval), 128'(1));
        lval = 4'b0000;
        mrdy = 1'b0;
        @(negedge clk);

        rr_m  = 0;
        err_m = 0;
        q_m.delete();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) lmsg[i] = REQ_W'({$urandom(), $urandom(), $urandom()});
            lval = 4'($urandom());
            mrdy = ($urandom() % 4) != 0;
            rv   = (q_m.size() > 0) && (($urandom() % 3) == 0);
            rmsg = RESP_W'({$urandom(), $urandom()});
            #1;
            model_step();
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
